// File: rtl/line_mem_ctrl_pkg.sv
// Shared definitions for the line memory controller: FSM encoding,
// default geometry and width helpers used by the controller and the array.
package line_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int unsigned WORD_W_DEF     = 32;
  localparam int unsigned LINE_WORDS_DEF = 4;
  localparam int unsigned DEPTH_DEF      = 64;
  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned LATENCY_DEF    = 2;

  // Word-offset bits within a line (OFF_W)
  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // Array index bits (IDX_W)
  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Latency counter bits (LAT_W)
  function automatic int unsigned lat_w(input int unsigned latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/line_mem_if.sv
// Request/response port of the line memory controller.
interface line_mem_if #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
);
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic                         req_line;
  logic [ADDR_W-1:0]            req_addr;
  logic [WORD_W*LINE_WORDS-1:0] req_wdata;
  logic [LINE_WORDS-1:0]        req_wmask;
  logic [WORD_W-1:0]            req_wword;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [WORD_W*LINE_WORDS-1:0] resp_line;
  logic [WORD_W-1:0]            resp_word;
  logic                         resp_err;

  modport master (
    output req_valid, req_write, req_line, req_addr, req_wdata, req_wmask,
           req_wword, resp_ready,
    input  req_ready, resp_valid, resp_line, resp_word, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_line, req_addr, req_wdata, req_wmask,
           req_wword, resp_ready,
    output req_ready, resp_valid, resp_line, resp_word, resp_err
  );
endinterface

// File: rtl/line_mem_array.sv
// DEPTH x WORD_W storage with LINE_WORDS write lanes and a combinational
// read of LINE_WORDS consecutive words starting at rd_base.
module line_mem_array
  import line_mem_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  localparam int unsigned IDX_W     = idx_w(DEPTH),
  localparam int unsigned LINE_W    = WORD_W * LINE_WORDS
) (
  input  logic                  clk,
  input  logic [LINE_WORDS-1:0] wr_en,
  input  logic [IDX_W-1:0]      wr_base,
  input  logic [LINE_W-1:0]     wr_data,
  input  logic [IDX_W-1:0]      rd_base,
  output logic [LINE_W-1:0]     rd_line
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Lane i writes word wr_base+i; lanes above 0 are only enabled for aligned line bases
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
      if (wr_en[i]) mem_q[wr_base + IDX_W'(i)] <= wr_data[i*WORD_W +: WORD_W];
    end
  end

  // Read lanes that fall past the end of the array return zero
  always_comb begin
    rd_line = '0;
    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
      if (({1'b0, rd_base} + (IDX_W+1)'(i)) < (IDX_W+1)'(DEPTH))
        rd_line[i*WORD_W +: WORD_W] = mem_q[rd_base + IDX_W'(i)];
    end
  end

endmodule

// File: rtl/line_mem_ctrl.sv
// Line memory controller: post-reset clear sweep, single outstanding
// word/line request with programmable latency, masked line writes and
// range checking in front of line_mem_array.
module line_mem_ctrl
  import line_mem_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned LATENCY    = LATENCY_DEF
) (
  input  logic       clk,
  input  logic       reset,
  line_mem_if.slave  bus,
  output logic       init_done
);

  localparam int unsigned OFF_W  = off_w(LINE_WORDS);
  localparam int unsigned IDX_W  = idx_w(DEPTH);
  localparam int unsigned LAT_W  = lat_w(LATENCY);
  localparam int unsigned LINE_W = WORD_W * LINE_WORDS;

  state_e              state_q, state_d;
  logic [LAT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                init_done_q, init_done_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [LINE_W-1:0]   resp_line_q, resp_line_d;
  logic [WORD_W-1:0]   resp_word_q, resp_word_d;

  logic                  accept;
  logic                  oor;
  logic [ADDR_W-1:0]     addr_eff;
  logic [IDX_W-1:0]      req_idx;
  logic [LINE_WORDS-1:0] wr_en;
  logic [IDX_W-1:0]      wr_base;
  logic [LINE_W-1:0]     wr_data;
  logic [LINE_W-1:0]     rd_line;

  // Request decode: line ops drop offset bits; range check on the full address
  always_comb begin
    accept   = req_ready_q && bus.req_valid;
    addr_eff = bus.req_addr;
    if (bus.req_line) addr_eff[OFF_W-1:0] = '0;
    oor      = addr_eff >= ADDR_W'(DEPTH);
    req_idx  = addr_eff[IDX_W-1:0];
  end

  // Array write port: sweep clear in INIT, in-range request writes on accept
  always_comb begin
    wr_en   = '0;
    wr_base = req_idx;
    wr_data = bus.req_wdata;
    if (state_q == ST_INIT) begin
      wr_en   = LINE_WORDS'(1);
      wr_base = ptr_q;
      wr_data = '0;
    end else if (accept && bus.req_write && !oor) begin
      if (bus.req_line) begin
        wr_en = bus.req_wmask;
      end else begin
        wr_en   = LINE_WORDS'(1);
        wr_data = LINE_W'(bus.req_wword);
      end
    end
  end

  line_mem_array #(
    .WORD_W     (WORD_W),
    .LINE_WORDS (LINE_WORDS),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_base (wr_base),
    .wr_data (wr_data),
    .rd_base (req_idx),
    .rd_line (rd_line)
  );

  // Next-state and response register computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    init_done_d  = init_done_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_line_d  = resp_line_q;
    resp_word_d  = resp_word_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == IDX_W'(DEPTH - 1)) begin
          ptr_d       = '0;
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          req_ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          // Always pass through WAIT (also for LATENCY==1) so resp_valid
          // rises exactly LATENCY cycles after the accept edge.
          req_ready_d = 1'b0;
          state_d     = ST_WAIT;
          cnt_d       = LAT_W'(LATENCY - 1);
          resp_err_d  = oor;
          resp_line_d = '0;
          resp_word_d = '0;
          if (!bus.req_write && !oor) begin
            if (bus.req_line) resp_line_d = rd_line;
            else              resp_word_d = rd_line[WORD_W-1:0];
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and output registers; reset restarts the sweep and drops any response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      ptr_q        <= '0;
      init_done_q  <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_line_q  <= '0;
      resp_word_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      init_done_q  <= init_done_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_line_q  <= resp_line_d;
      resp_word_q  <= resp_word_d;
    end
  end

  assign init_done      = init_done_q;
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_valid_q & resp_err_q;
  assign bus.resp_line  = resp_valid_q ? resp_line_q : '0;
  assign bus.resp_word  = resp_valid_q ? resp_word_q : '0;

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Directed bench for line_mem_ctrl: instance A uses the default geometry
// (LINE_WORDS=4, DEPTH=64, LATENCY=2), instance B uses LINE_WORDS=8,
// DEPTH=256, LATENCY=1.
module tb_line_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic done_a, done_b;

  line_mem_if #(.WORD_W(32), .LINE_WORDS(4), .ADDR_W(32)) ba ();
  line_mem_if #(.WORD_W(32), .LINE_WORDS(8), .ADDR_W(32)) bb ();

  line_mem_ctrl #(
    .WORD_W(32), .LINE_WORDS(4), .DEPTH(64), .ADDR_W(32), .LATENCY(2)
  ) dut_a (
    .clk(clk), .reset(rst_a), .bus(ba), .init_done(done_a)
  );

  line_mem_ctrl #(
    .WORD_W(32), .LINE_WORDS(8), .DEPTH(256), .ADDR_W(32), .LATENCY(1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .bus(bb), .init_done(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic f_rdy(input int sel);
    return (sel != 0) ? bb.req_ready : ba.req_ready;
  endfunction
  function automatic logic f_rv(input int sel);
    return (sel != 0) ? bb.resp_valid : ba.resp_valid;
  endfunction
  function automatic logic f_done(input int sel);
    return (sel != 0) ? done_b : done_a;
  endfunction
  function automatic logic f_err(input int sel);
    return (sel != 0) ? bb.resp_err : ba.resp_err;
  endfunction
  function automatic logic [31:0] f_word(input int sel);
    return (sel != 0) ? bb.resp_word : ba.resp_word;
  endfunction
  function automatic logic [255:0] f_line(input int sel);
    return (sel != 0) ? bb.resp_line : {128'h0, ba.resp_line};
  endfunction

  task automatic drive(input int sel, input logic v, input logic wr, input logic ln,
                       input logic [31:0] addr, input logic [255:0] wdata,
                       input logic [7:0] wmask, input logic [31:0] wword);
    if (sel == 0) begin
      ba.req_valid = v;   ba.req_write = wr;  ba.req_line = ln;  ba.req_addr = addr;
      ba.req_wdata = wdata[127:0];  ba.req_wmask = wmask[3:0];  ba.req_wword = wword;
    end else begin
      bb.req_valid = v;   bb.req_write = wr;  bb.req_line = ln;  bb.req_addr = addr;
      bb.req_wdata = wdata;  bb.req_wmask = wmask;  bb.req_wword = wword;
    end
  endtask

  task automatic set_rr(input int sel, input logic v);
    if (sel == 0) ba.resp_ready = v;
    else          bb.resp_ready = v;
  endtask

  // Release reset and time the clear sweep
  task automatic sweep(input int sel, input int depth, input string tag);
    logic early;
    early = 1'b0;
    if (sel == 0) rst_a = 1'b1;
    else          rst_b = 1'b1;
    for (int k = 1; k <= depth; k++) begin
      tick();
      if (k < depth && (f_rdy(sel) || f_done(sel))) early = 1'b1;
    end
    check({tag, "_early"}, 256'(early), 256'(0));
    check({tag, "_done"}, 256'(f_done(sel)), 256'(1));
    check({tag, "_rdy"}, 256'(f_rdy(sel)), 256'(1));
  endtask

  // One request/response; optionally holds resp_ready low for 'hold' cycles
  task automatic xfer(input int sel, input string tag, input logic wr, input logic ln,
                      input logic [31:0] addr, input logic [255:0] wdata,
                      input logic [7:0] wmask, input logic [31:0] wword, input int hold,
                      output int acc_wait, output int lat, output logic [255:0] line,
                      output logic [31:0] word, output logic err);
    logic bad;
    drive(sel, 1'b1, wr, ln, addr, wdata, wmask, wword);
    acc_wait = 0;
    while (!f_rdy(sel) && acc_wait < 300) begin
      tick();
      acc_wait++;
    end
    tick();
    drive(sel, 1'b0, ~wr, ~ln, ~addr, ~wdata, ~wmask, ~wword);
    lat = 0;
    while (!f_rv(sel) && lat < 50) begin
      tick();
      lat++;
    end
    line = f_line(sel);
    word = f_word(sel);
    err  = f_err(sel);
    if (hold > 0) begin
      bad = 1'b0;
      for (int h = 0; h < hold; h++) begin
        tick();
        if (!f_rv(sel) || f_rdy(sel) || f_line(sel) !== line ||
            f_word(sel) !== word || f_err(sel) !== err) bad = 1'b1;
      end
      check({tag, "_hold"}, 256'(bad), 256'(0));
    end
    set_rr(sel, 1'b1);
    tick();
    set_rr(sel, 1'b0);
    check({tag, "_drop"}, 256'(f_rv(sel)), 256'(0));
  endtask

  task automatic op(input int sel, input string tag, input logic wr, input logic ln,
                    input logic [31:0] addr, input logic [255:0] wdata,
                    input logic [7:0] wmask, input logic [31:0] wword,
                    input int exp_lat, input logic exp_err, input logic [255:0] exp_data);
    int aw, lat;
    logic [255:0] line;
    logic [31:0] word;
    logic err;
    xfer(sel, tag, wr, ln, addr, wdata, wmask, wword, 0, aw, lat, line, word, err);
    check({tag, "_lat"}, 256'(lat), 256'(exp_lat));
    check({tag, "_err"}, 256'(err), 256'(exp_err));
    check({tag, "_data"}, ln ? line : {224'h0, word}, exp_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw, lat;
    logic [255:0] line, old_l, new_l, exp_l;
    logic [31:0] word;
    logic err;

    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_rr(0, 1'b0);
    set_rr(1, 1'b0);
    tick();
    tick();

    // ---------------- instance A ----------------
    check("a_rst_ready", 256'(ba.req_ready), 256'(0));
    check("a_rst_valid", 256'(ba.resp_valid), 256'(0));
    check("a_rst_done", 256'(done_a), 256'(0));
    check("a_rst_line", {128'h0, ba.resp_line}, '0);
    sweep(0, 64, "a_init");
    for (int i = 0; i < 16; i++)
      op(0, "a_zero", 1'b0, 1'b1, 32'(i * 4), '0, 8'h0, '0, 2, 1'b0, '0);

    op(0, "a_ww17", 1'b1, 1'b0, 32'd17, '0, 8'h0, 32'h455, 2, 1'b0, '0);
    op(0, "a_rw17", 1'b0, 1'b0, 32'd17, '0, 8'h0, '0, 2, 1'b0, 256'h455);

    op(0, "a_lw8", 1'b1, 1'b1, 32'd8,
       {128'h0, 128'hAAAA_0003_AAAA_0002_AAAA_0001_AAAA_0000}, 8'h0F, '0, 2, 1'b0, '0);
    op(0, "a_lw0a", 1'b1, 1'b1, 32'h0A,
       {128'h0, 128'hDDDD_0003_DDDD_0002_DDDD_0001_DDDD_0000}, 8'h05, '0, 2, 1'b0, '0);
    op(0, "a_lr8", 1'b0, 1'b1, 32'd8, '0, 8'h0, '0, 2, 1'b0,
       {128'h0, 128'hAAAA_0003_DDDD_0002_AAAA_0001_DDDD_0000});
    op(0, "a_lw_m0", 1'b1, 1'b1, 32'd9, '1, 8'h00, '0, 2, 1'b0, '0);
    op(0, "a_lr8b", 1'b0, 1'b1, 32'd11, '0, 8'h0, '0, 2, 1'b0,
       {128'h0, 128'hAAAA_0003_DDDD_0002_AAAA_0001_DDDD_0000});

    op(0, "a_r64", 1'b0, 1'b0, 32'd64, '0, 8'h0, '0, 2, 1'b1, '0);
    op(0, "a_lw70", 1'b1, 1'b1, 32'd70, '1, 8'h0F, '0, 2, 1'b1, '0);
    op(0, "a_ww_hi", 1'b1, 1'b0, 32'h1000_0011, '0, 8'h0, 32'hBAD, 2, 1'b1, '0);
    op(0, "a_lr_hi", 1'b0, 1'b1, 32'h1000_0010, '0, 8'h0, '0, 2, 1'b1, '0);
    op(0, "a_lr4", 1'b0, 1'b1, 32'd4, '0, 8'h0, '0, 2, 1'b0, '0);
    op(0, "a_lr16", 1'b0, 1'b1, 32'd16, '0, 8'h0, '0, 2, 1'b0,
       {128'h0, 128'h0000_0000_0000_0000_0000_0455_0000_0000});
    op(0, "a_ww63", 1'b1, 1'b0, 32'd63, '0, 8'h0, 32'hCAFE, 2, 1'b0, '0);
    op(0, "a_lr60", 1'b0, 1'b1, 32'd61, '0, 8'h0, '0, 2, 1'b0,
       {128'h0, 128'h0000_CAFE_0000_0000_0000_0000_0000_0000});

    xfer(0, "a_hold", 1'b0, 1'b0, 32'd17, '0, 8'h0, '0, 5, aw, lat, line, word, err);
    check("a_hold_lat", 256'(lat), 256'(2));
    check("a_hold_word", 256'(word), 256'h455);
    xfer(0, "a_next", 1'b0, 1'b0, 32'd63, '0, 8'h0, '0, 0, aw, lat, line, word, err);
    check("a_next_acc", 256'(aw), 256'(0));
    check("a_next_word", 256'(word), 256'hCAFE);

    // reset while a response is being presented
    drive(0, 1'b1, 1'b0, 1'b0, 32'd17, '0, 8'h0, '0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    tick();
    tick();
    check("a_resp_pre", 256'(ba.resp_valid), 256'(1));
    rst_a = 1'b0;
    #1;
    check("a_resp_rst_valid", 256'(ba.resp_valid), 256'(0));
    check("a_resp_rst_word", 256'(ba.resp_word), 256'(0));
    tick();
    sweep(0, 64, "a_init2");

    // reset while waiting for the latency to expire
    op(0, "a_ww5", 1'b1, 1'b0, 32'd5, '0, 8'h0, 32'h1234, 2, 1'b0, '0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'd5, '0, 8'h0, '0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    rst_a = 1'b0;
    #1;
    check("a_wait_rst_ready", 256'(ba.req_ready), 256'(0));
    check("a_wait_rst_done", 256'(done_a), 256'(0));
    tick();
    tick();
    check("a_wait_rst_valid", 256'(ba.resp_valid), 256'(0));
    tick();
    sweep(0, 64, "a_init3");
    op(0, "a_rw5_clr", 1'b0, 1'b0, 32'd5, '0, 8'h0, '0, 2, 1'b0, '0);
    op(0, "a_rw17_clr", 1'b0, 1'b0, 32'd17, '0, 8'h0, '0, 2, 1'b0, '0);
    op(0, "a_lr8_clr", 1'b0, 1'b1, 32'd8, '0, 8'h0, '0, 2, 1'b0, '0);

    // ---------------- instance B ----------------
    check("b_rst_ready", 256'(bb.req_ready), 256'(0));
    check("b_rst_done", 256'(done_b), 256'(0));
    sweep(1, 256, "b_init");
    op(1, "b_ww17", 1'b1, 1'b0, 32'd17, '0, 8'h0, 32'h455, 1, 1'b0, '0);
    op(1, "b_rw17", 1'b0, 1'b0, 32'd17, '0, 8'h0, '0, 1, 1'b0, 256'h455);

    for (int i = 0; i < 8; i++) begin
      old_l[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      new_l[i*32 +: 32] = 32'hD000_0000 + 32'(i);
      exp_l[i*32 +: 32] = (i % 2 == 0) ? 32'hD000_0000 + 32'(i) : 32'hA000_0000 + 32'(i);
    end
    op(1, "b_lw8", 1'b1, 1'b1, 32'd8, old_l, 8'hFF, '0, 1, 1'b0, '0);
    op(1, "b_lw0a", 1'b1, 1'b1, 32'h0A, new_l, 8'h55, '0, 1, 1'b0, '0);
    op(1, "b_lr8", 1'b0, 1'b1, 32'd8, '0, 8'h0, '0, 1, 1'b0, exp_l);

    op(1, "b_r256", 1'b0, 1'b0, 32'd256, '0, 8'h0, '0, 1, 1'b1, '0);
    op(1, "b_lw260", 1'b1, 1'b1, 32'd260, '1, 8'hFF, '0, 1, 1'b1, '0);
    op(1, "b_lr0", 1'b0, 1'b1, 32'd0, '0, 8'h0, '0, 1, 1'b0, '0);
    op(1, "b_ww255", 1'b1, 1'b0, 32'd255, '0, 8'h0, 32'hBEEF, 1, 1'b0, '0);
    op(1, "b_rw255", 1'b0, 1'b0, 32'd255, '0, 8'h0, '0, 1, 1'b0, 256'hBEEF);

    xfer(1, "b_hold", 1'b0, 1'b0, 32'd17, '0, 8'h0, '0, 5, aw, lat, line, word, err);
    check("b_hold_lat", 256'(lat), 256'(1));
    check("b_hold_word", 256'(word), 256'h455);
    xfer(1, "b_next", 1'b0, 1'b0, 32'd255, '0, 8'h0, '0, 0, aw, lat, line, word, err);
    check("b_next_acc", 256'(aw), 256'(0));
    check("b_next_word", 256'(word), 256'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
